// File: rtl/switch_pkg.sv
// Shared types and constants for the switch output-port receive path.
package switch_pkg;

  localparam int BYTE_W    = 8;
  localparam int HDR_BYTES = 3;
  localparam int FCS_BYTES = 1;

  typedef enum logic [2:0] {
    ST_DA,
    ST_SA,
    ST_LEN,
    ST_PAY,
    ST_FCS
  } rx_state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              sop;
    logic              eop;
    logic              err;
  } rx_beat_t;

  // Total on-wire length of a packet carrying len payload bytes.
  function automatic int pkt_bytes(input logic [BYTE_W-1:0] len);
    return HDR_BYTES + int'(len) + FCS_BYTES;
  endfunction

endpackage

// File: rtl/switch_rx_skid.sv
// Two-entry beat buffer between the port FIFO read path and the downstream
// consumer; push and pop may happen in the same cycle.
module switch_rx_skid
  import switch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  rx_beat_t   push_beat,
  input  logic       pop,
  output rx_beat_t   head,
  output logic [1:0] occupancy
);

  rx_beat_t   mem_q [2];
  rx_beat_t   mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_beat;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign occupancy = count_q;

endmodule

// File: rtl/switch_port_rx.sv
// Receive endpoint for one switch output port: drains the port FIFO, frames
// DA/SA/LEN/payload/FCS, flags bad packets. Optional stats: SWITCH_PORT_RX_STATS_EN.
module switch_port_rx
  import switch_pkg::*;
#(
  parameter logic [BYTE_W-1:0] MY_ADDR = 8'h00,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  output logic              read,
  input  logic [BYTE_W-1:0] port_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_err,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  err_count
);

  // Handshake: a beat transfers downstream on any cycle with out_valid & out_ready;
  // out_data/sop/eop/err are stable while out_valid is high and unaccepted.
  rx_state_t         state_q, state_d;
  logic [BYTE_W-1:0] acc_q, acc_d;
  logic [BYTE_W-1:0] len_q, len_d;
  logic              da_ok_q, da_ok_d;
  logic              in_flight_q, in_flight_d;
  logic              push, pop;
  rx_beat_t          push_beat, head;
  logic [1:0]        skid_occ, occ_after_pop;

  // Counting the slot freed by this cycle's pop keeps a 1 byte/cycle stream.
  assign pop           = out_valid & out_ready;
  assign occ_after_pop = skid_occ - {1'b0, pop};
  assign read          = ready & ~reset & ((occ_after_pop + {1'b0, in_flight_q}) < 2'd2);
  assign in_flight_d   = read;
  assign push          = in_flight_q;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    len_d     = len_q;
    da_ok_d   = da_ok_q;
    push_beat = '{data: port_data, sop: 1'b0, eop: 1'b0, err: 1'b0};
    if (push) begin
      unique case (state_q)
        ST_DA: begin
          push_beat.sop = 1'b1;
          acc_d         = port_data;
          da_ok_d       = (port_data == MY_ADDR);
          state_d       = ST_SA;
        end
        ST_SA: begin
          acc_d   = acc_q ^ port_data;
          state_d = ST_LEN;
        end
        ST_LEN: begin
          acc_d   = acc_q ^ port_data;
          len_d   = port_data;
          state_d = (port_data != '0) ? ST_PAY : ST_FCS;
        end
        ST_PAY: begin
          acc_d = acc_q ^ port_data;
          len_d = len_q - 8'd1;
          if (len_q == 8'd1) begin
            state_d = ST_FCS;
          end
        end
        ST_FCS: begin
          push_beat.eop = 1'b1;
          push_beat.err = (port_data != acc_q) | ~da_ok_q;
          state_d       = ST_DA;
        end
        default: state_d = ST_DA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_DA;
      acc_q       <= '0;
      len_q       <= '0;
      da_ok_q     <= 1'b0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      da_ok_q     <= da_ok_d;
      in_flight_q <= in_flight_d;
    end
  end

  switch_rx_skid u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_beat (push_beat),
    .pop       (pop),
    .head      (head),
    .occupancy (skid_occ)
  );

  assign out_valid = (skid_occ != 2'd0);
  assign out_data  = out_valid ? head.data : '0;
  assign out_sop   = out_valid & head.sop;
  assign out_eop   = out_valid & head.eop;
  assign out_err   = out_valid & head.eop & head.err;

`ifdef SWITCH_PORT_RX_STATS_EN
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // Counters advance as the eop beat leaves, and stick at all-ones.
  always_comb begin
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;
    if (pop & head.eop) begin
      if (head.err) begin
        if (~&err_count_q) err_count_d = err_count_q + CNT_W'(1);
      end else begin
        if (~&pkt_count_q) pkt_count_d = pkt_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_q <= '0;
      err_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_switch_port_rx.sv
// Self-checking bench for switch_port_rx: port FIFO model, beat scoreboard,
// scenario tasks run in sequence.
module tb_switch_port_rx;
  import switch_pkg::*;

  localparam logic [7:0] MY_ADDR = 8'h55;
  localparam int         CNT_W   = 16;
`ifdef SWITCH_PORT_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ready = 1'b0;
  logic             read;
  logic [7:0]       port_data = 8'h00;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_data;
  logic             out_sop, out_eop, out_err;
  logic [CNT_W-1:0] pkt_count, err_count;

  int compared = 0;
  int mismatched = 0;

  logic [10:0] exp_q[$];   // {data, sop, eop, err}
  logic [7:0]  fifo_q[$];
  logic [7:0]  pay_q[$];
  logic [10:0] mon_exp;
  int          exp_pkt = 0;
  int          exp_err = 0;
  int          cyc = 0;
  int          first_pop = -1;
  int          last_pop = -1;
  logic        read_neg = 1'b0;
  logic        ready_en = 1'b0;
  logic [15:0] want_pkt, want_err;

  switch_port_rx #(.MY_ADDR(MY_ADDR), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .ready     (ready),
    .read      (read),
    .port_data (port_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_err   (out_err),
    .pkt_count (pkt_count),
    .err_count (err_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- port FIFO model ----------------
  always @(negedge clk) read_neg = read;

  always @(posedge clk) begin
    if (read_neg) begin
      if (fifo_q.size() == 0) begin
        mismatched++;
        $display("FAIL fifo_underflow: read popped an empty FIFO");
      end else begin
        port_data <= fifo_q.pop_front();
      end
    end
    ready <= ready_en && (fifo_q.size() != 0);
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (read && !ready) begin
        mismatched++;
        $display("FAIL read_without_ready: read=1 ready=0 at cycle %0d", cyc);
      end
      if (dut.skid_occ == 2'd2 && dut.push && !(out_valid && out_ready)) begin
        mismatched++;
        $display("FAIL skid_overflow: push into full skid at cycle %0d", cyc);
      end
      if (out_valid && out_ready) begin
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL beat_unexpected: got data=%h sop=%b eop=%b err=%b, none expected",
                   out_data, out_sop, out_eop, out_err);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({out_data, out_sop, out_eop, out_err} !== mon_exp) begin
            mismatched++;
            $display("FAIL beat: got data=%h sop=%b eop=%b err=%b, want data=%h sop=%b eop=%b err=%b",
                     out_data, out_sop, out_eop, out_err,
                     mon_exp[10:3], mon_exp[2], mon_exp[1], mon_exp[0]);
          end
          if (mon_exp[1]) begin
            if (mon_exp[0]) exp_err++;
            else            exp_pkt++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Loads a packet (DA, SA, LEN=pay_q.size(), payload, FCS^fcs_flip) into the FIFO.
  task automatic send_pkt(input logic [7:0] da, input logic [7:0] sa, input logic [7:0] fcs_flip);
    logic [7:0] len;
    logic [7:0] fcs;
    logic       bad;
    len = 8'(pay_q.size());
    fcs = da ^ sa ^ len;
    foreach (pay_q[i]) fcs = fcs ^ pay_q[i];
    bad = (fcs_flip != 8'h00) || (da != MY_ADDR);
    fcs = fcs ^ fcs_flip;
    fifo_q.push_back(da);  exp_q.push_back({da, 1'b1, 1'b0, 1'b0});
    fifo_q.push_back(sa);  exp_q.push_back({sa, 1'b0, 1'b0, 1'b0});
    fifo_q.push_back(len); exp_q.push_back({len, 1'b0, 1'b0, 1'b0});
    foreach (pay_q[i]) begin
      fifo_q.push_back(pay_q[i]);
      exp_q.push_back({pay_q[i], 1'b0, 1'b0, 1'b0});
    end
    fifo_q.push_back(fcs); exp_q.push_back({fcs, 1'b0, 1'b1, bad});
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !out_valid && !dut.push) done = 1'b1;
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("FAIL %s_drain: %0d beats still expected after %0d cycles, want 0",
               name, exp_q.size(), budget);
      exp_q.delete();
      fifo_q.delete();
    end
  endtask

  task automatic check_counters(input string name);
    want_pkt = STATS ? exp_pkt[15:0] : 16'd0;
    want_err = STATS ? exp_err[15:0] : 16'd0;
    compared++;
    if (pkt_count !== want_pkt) begin
      mismatched++;
      $display("FAIL %s_pkt_count: got %0d want %0d", name, pkt_count, want_pkt);
    end
    compared++;
    if (err_count !== want_err) begin
      mismatched++;
      $display("FAIL %s_err_count: got %0d want %0d", name, err_count, want_err);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; ready_en = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({read, out_valid, out_data, out_sop, out_eop, out_err} !== 13'd0) begin
      mismatched++;
      $display("FAIL reset_outputs: got read=%b valid=%b data=%h sop=%b eop=%b err=%b, want all 0",
               read, out_valid, out_data, out_sop, out_eop, out_err);
    end
    compared++;
    if ({pkt_count, err_count} !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_counters: got pkt=%0d err=%0d want 0/0", pkt_count, err_count);
    end
    reset = 1'b0;
    ready_en = 1'b1;
  endtask

  task automatic test_good_packet();
    int rd_c, ov_c;
    rd_c = -1; ov_c = -1;
    pay_q = '{8'h01, 8'h02, 8'h03};
    send_pkt(MY_ADDR, 8'hAA, 8'h00);
    for (int i = 0; i < 20 && ov_c < 0; i++) begin
      @(negedge clk);
      if (read && rd_c < 0) rd_c = cyc;
      if (out_valid && ov_c < 0) ov_c = cyc;
    end
    compared++;
    if (rd_c < 0 || ov_c < 0 || (ov_c - rd_c) != 2) begin
      mismatched++;
      $display("FAIL good_latency: got read@%0d valid@%0d, want 2 cycles apart", rd_c, ov_c);
    end
    wait_drain(50, "good");
    check_counters("good");
  endtask

  task automatic test_bad_fcs();
    pay_q = '{8'h01, 8'h02, 8'h03};
    send_pkt(MY_ADDR, 8'hAA, 8'h03);
    wait_drain(50, "bad_fcs");
    check_counters("bad_fcs");
  endtask

  task automatic test_wrong_da();
    pay_q = '{8'h01, 8'h02, 8'h03};
    send_pkt(8'h66, 8'hAA, 8'h00);
    wait_drain(50, "wrong_da");
    check_counters("wrong_da");
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int         full_seen;
    bit         drained;
    pat = 4'b1001;
    full_seen = 0;
    drained = 1'b0;
    pay_q.delete();
    for (int i = 0; i < 6; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    send_pkt(MY_ADDR, 8'($urandom_range(0, 255)), 8'h00);
    for (int i = 0; i < 200 && !drained; i++) begin
      @(posedge clk); #1;
      out_ready = pat[i % 4];
      @(negedge clk);
      if (dut.skid_occ == 2'd2 && !out_ready) begin
        full_seen++;
        compared++;
        if (read !== 1'b0) begin
          mismatched++;
          $display("FAIL bp_read_when_full: got read=%b want 0", read);
        end
      end
      drained = (fifo_q.size() == 0 && exp_q.size() == 0 && !out_valid && !dut.push);
    end
    out_ready = 1'b1;
    compared++;
    if (full_seen == 0) begin
      mismatched++;
      $display("FAIL bp_full_seen: got %0d full cycles, want >0", full_seen);
    end
    wait_drain(50, "bp");
    check_counters("bp");
  endtask

  task automatic test_back_to_back();
    pay_q.delete();
    send_pkt(MY_ADDR, 8'h11, 8'h00);
    pay_q = '{8'h09};
    send_pkt(MY_ADDR, 8'h22, 8'h00);
    first_pop = -1;
    wait_drain(50, "b2b");
    compared++;
    if (last_pop - first_pop != 8) begin
      mismatched++;
      $display("FAIL b2b_throughput: got %0d cycles for 9 beats, want 8", last_pop - first_pop);
    end
    check_counters("b2b");
  endtask

  task automatic test_len_max();
    pay_q.delete();
    for (int i = 0; i < 255; i++) pay_q.push_back(8'($urandom_range(0, 255)));
    send_pkt(MY_ADDR, 8'($urandom_range(0, 255)), 8'h00);
    wait_drain(pkt_bytes(8'd255) + 50, "len_max");
    check_counters("len_max");
  endtask

  task automatic test_random();
    bit         drained;
    logic [7:0] da;
    logic [7:0] flip;
    drained = 1'b0;
    for (int p = 0; p < 8; p++) begin
      pay_q.delete();
      for (int i = 0; i < int'($urandom_range(0, 12)); i++) pay_q.push_back(8'($urandom_range(0, 255)));
      da   = ($urandom_range(0, 3) == 0) ? 8'h3C : MY_ADDR;
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_pkt(da, 8'($urandom_range(0, 255)), flip);
    end
    for (int i = 0; i < 3000 && !drained; i++) begin
      @(posedge clk); #1;
      ready_en  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drained = (fifo_q.size() == 0 && exp_q.size() == 0 && !out_valid && !dut.push);
    end
    ready_en = 1'b1;
    out_ready = 1'b1;
    wait_drain(50, "random");
    check_counters("random");
  endtask

  task automatic test_reset_mid();
    fifo_q.push_back(MY_ADDR); exp_q.push_back({MY_ADDR, 1'b1, 1'b0, 1'b0});
    fifo_q.push_back(8'h33);   exp_q.push_back({8'h33, 1'b0, 1'b0, 1'b0});
    fifo_q.push_back(8'h02);   exp_q.push_back({8'h02, 1'b0, 1'b0, 1'b0});
    wait_drain(50, "partial");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_pkt = 0;
    exp_err = 0;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_mid_valid: got %b want 0", out_valid);
    end
    check_counters("reset_mid_clear");
    pay_q = '{8'hAB};
    send_pkt(MY_ADDR, 8'h44, 8'h00);
    wait_drain(50, "reset_mid");
    check_counters("reset_mid");
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_fcs();
    test_wrong_da();
    test_backpressure();
    test_back_to_back();
    test_len_max();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
